fright_mode_ctrl: RTL and testbench
===================================

Name: fright_mode_ctrl

Overview:
- Ghost-side end of the pellet/ghost interface: consumes the big-pellet pulse and produces the frightened-timer and ghost-intercept signals that the pellet/score block samples.
- Runs a per-ghost NORMAL/FRIGHT/EATEN state machine paced by the frame tick and checks pacman-ghost proximity.
- Reports pacman capture to the game controller.
- One instance per ghost, in the same clk domain as the pellet block.

Parameters:
- FRIGHT_FRAMES, 200: frightened duration in frames (1..255).
- FLASH_FRAMES, 60: final frames of FRIGHT during which the ghost flashes (< FRIGHT_FRAMES).
- RESPAWN_FRAMES, 120: frames the ghost stays EATEN before returning to NORMAL (1..255).
- HIT_RADIUS, 12: collision when |dx| < HIT_RADIUS and |dy| < HIT_RADIUS, in pixels.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- big_pellet_eaten  in  1  one-cycle pulse from the pellet block
- win  in  1  level; freezes the block
- pacX, pacY  in  10 each  pacman position, pixels
- ghostX, ghostY  in  10 each  ghost position, pixels
- ghost_survival_timer  out  8  remaining FRIGHT or EATEN frames; 0 in NORMAL
- slow_ghost_intercept  out  1  one-cycle pulse: pacman ate frightened ghost
- ghost_state  out  2  00 NORMAL, 01 FRIGHT, 10 EATEN (11 unused)
- ghost_flash  out  1  flash-colour select for the renderer
- pacman_caught  out  1  one-cycle pulse: NORMAL ghost touched pacman

Behaviour:
- Reset values: state NORMAL, timer 0, intercept 0, caught 0, flash 0, caught_lock 0. Reset mid-FRIGHT or mid-EATEN aborts to NORMAL on the next edge.
- hit is combinational: unsigned absolute differences of 10-bit positions (11-bit intermediate, no wrap), both less than HIT_RADIUS.
- All outputs are registered; a pulse appears on the cycle after its cause.
- Freeze: win=1 holds state, timer and lock unchanged; intercept and caught are forced to 0.
- NORMAL:
  - big_pellet_eaten → FRIGHT, timer <= FRIGHT_FRAMES.
  - Otherwise, hit with caught_lock=0 → pacman_caught=1 for one cycle, caught_lock <= 1.
  - caught_lock clears on the first cycle with hit=0.
  - Simultaneous big pellet and hit: the pellet wins, no caught pulse.
- FRIGHT:
  - hit → slow_ghost_intercept=1 for one cycle, state EATEN, timer <= RESPAWN_FRAMES. A simultaneous big pellet or frame_tick is ignored.
  - Else big_pellet_eaten → timer reloads to FRIGHT_FRAMES; reload beats a coincident frame_tick.
  - Else frame_tick → timer decrements. Decrement from 1 → timer 0 and state NORMAL on the same edge.
- EATEN:
  - hit and big_pellet_eaten are ignored; no pulses.
  - frame_tick decrements the timer; 1 → 0 returns to NORMAL with caught_lock <= hit. A ghost respawning on top of pacman therefore does not instantly catch.
- ghost_flash is 1 only when state=FRIGHT and 0 < timer <= FLASH_FRAMES (steady form); 0 in NORMAL and EATEN.
- slow_ghost_intercept and pacman_caught are never both 1 in the same cycle.
- The timer never underflows; frame_tick in NORMAL has no effect.
- Contract with the pellet block: it re-arms its ghost bonus when ghost_survival_timer==0, so the timer is held at 0 for the whole NORMAL state.

Optional Feature:
- Macro FRIGHT_BLINK_EN.
- Defined: inside the flash window, ghost_flash toggles every 8 frame_ticks. It starts at 1 on entering the window, and a blink counter resets on window entry and on reload.
- Undefined: ghost_flash is steady 1 inside the window, and the blink counter is not synthesised.
- NORMAL and EATEN behaviour are identical either way.

Test Plan (FRIGHT_FRAMES=10, FLASH_FRAMES=3, RESPAWN_FRAMES=5, HIT_RADIUS=12):
- Reset, no hit, 20 frame_ticks → state 00, timer 0, no pulses. Then big_pellet_eaten → next cycle state 01, timer 10.
- From FRIGHT: 7 ticks → timer 3, flash=1. 3 more ticks → timer 0, state 00, flash 0. A big pellet at timer 5 reloads to 10, including with a coincident frame_tick.
- In FRIGHT, ghost at (200,200), pacman at (211,200) → intercept high exactly 1 cycle, state 10, timer 5. Pacman at (212,200) → no hit.
- EATEN with overlap held: 5 ticks → NORMAL, no caught pulse. Separate, then re-overlap → one caught pulse. Holding overlap 100 cycles → still one pulse.
- NORMAL, same cycle hit + big_pellet_eaten → FRIGHT, no caught. FRIGHT, same cycle hit + big pellet → EATEN, intercept=1.
- win=1 mid-FRIGHT at timer 6 with 10 ticks and a hit → timer stays 6, no pulses. Release win → countdown resumes. reset asserted mid-EATEN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/fright_mode_ctrl.sv
// rtl/fright_mode_ctrl.sv - per-ghost NORMAL/FRIGHT/EATEN controller with pacman proximity check
// Optional macro FRIGHT_BLINK_EN: ghost_flash blinks every 8 frame ticks inside the flash window.
module fright_mode_ctrl #(
  parameter int FRIGHT_FRAMES  = 200,
  parameter int FLASH_FRAMES   = 60,
  parameter int RESPAWN_FRAMES = 120,
  parameter int HIT_RADIUS     = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       big_pellet_eaten,
  input  logic       win,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  output logic [7:0] ghost_survival_timer,
  output logic       slow_ghost_intercept,
  output logic [1:0] ghost_state,
  output logic       ghost_flash,
  output logic       pacman_caught
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    FRIGHT = 2'b01,
    EATEN  = 2'b10
  } state_t;

  localparam logic [7:0]  FRIGHT_LOAD  = 8'(FRIGHT_FRAMES);
  localparam logic [7:0]  RESPAWN_LOAD = 8'(RESPAWN_FRAMES);
  localparam logic [7:0]  FLASH_LIMIT  = 8'(FLASH_FRAMES);
  localparam logic [10:0] RADIUS       = 11'(HIT_RADIUS);

  state_t      state, state_n;
  logic [7:0]  timer, timer_n;
  logic        caught_lock, lock_n;
  logic        intercept_n, caught_n, flash_n, in_window_n;
  logic [10:0] dx, dy;
  logic        hit;

  // Widened to 11 bits so the difference never wraps at the screen edges.
  assign dx  = (pacX >= ghostX) ? ({1'b0, pacX} - {1'b0, ghostX}) : ({1'b0, ghostX} - {1'b0, pacX});
  assign dy  = (pacY >= ghostY) ? ({1'b0, pacY} - {1'b0, ghostY}) : ({1'b0, ghostY} - {1'b0, pacY});
  assign hit = (dx < RADIUS) && (dy < RADIUS);

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    lock_n      = caught_lock;
    intercept_n = 1'b0;
    caught_n    = 1'b0;
    if (!win) begin
      case (state)
        NORMAL: begin
          timer_n = 8'd0;
          if (big_pellet_eaten) begin
            state_n = FRIGHT;
            timer_n = FRIGHT_LOAD;
            if (!hit) lock_n = 1'b0;
          end else if (hit && !caught_lock) begin
            caught_n = 1'b1;
            lock_n   = 1'b1;
          end else if (!hit) begin
            lock_n = 1'b0;
          end
        end
        FRIGHT: begin
          if (hit) begin
            state_n     = EATEN;
            timer_n     = RESPAWN_LOAD;
            intercept_n = 1'b1;
          end else if (big_pellet_eaten) begin
            timer_n = FRIGHT_LOAD;
          end else if (frame_tick) begin
            if (timer <= 8'd1) begin
              state_n = NORMAL;
              timer_n = 8'd0;
              lock_n  = 1'b0;
            end else begin
              timer_n = timer - 8'd1;
            end
          end
        end
        EATEN: begin
          if (frame_tick) begin
            if (timer <= 8'd1) begin
              state_n = NORMAL;
              timer_n = 8'd0;
              lock_n  = hit;
            end else begin
              timer_n = timer - 8'd1;
            end
          end
        end
        default: begin
          state_n = NORMAL;
          timer_n = 8'd0;
          lock_n  = 1'b0;
        end
      endcase
    end
  end

  // Flash is derived from the next state/timer so it lines up with the registered outputs.
  assign in_window_n = (state_n == FRIGHT) && (timer_n != 8'd0) && (timer_n <= FLASH_LIMIT);

`ifdef FRIGHT_BLINK_EN
  logic [2:0] blink_cnt, blink_cnt_n;
  logic       blink_phase, blink_phase_n;
  logic       in_window;

  always_comb begin
    blink_cnt_n   = blink_cnt;
    blink_phase_n = blink_phase;
    if (!in_window_n || !in_window) begin
      blink_cnt_n   = 3'd0;
      blink_phase_n = 1'b1;
    end else if (frame_tick && !win) begin
      blink_cnt_n = blink_cnt + 3'd1;
      if (blink_cnt == 3'd7) blink_phase_n = ~blink_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= 3'd0;
      blink_phase <= 1'b1;
      in_window   <= 1'b0;
    end else begin
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
      in_window   <= in_window_n;
    end
  end

  assign flash_n = in_window_n && blink_phase_n;
`else
  assign flash_n = in_window_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= NORMAL;
      timer                <= 8'd0;
      caught_lock          <= 1'b0;
      slow_ghost_intercept <= 1'b0;
      pacman_caught        <= 1'b0;
      ghost_flash          <= 1'b0;
    end else begin
      state                <= state_n;
      timer                <= timer_n;
      caught_lock          <= lock_n;
      slow_ghost_intercept <= intercept_n;
      pacman_caught        <= caught_n;
      ghost_flash          <= flash_n;
    end
  end

  assign ghost_state          = state;
  assign ghost_survival_timer = timer;

endmodule

// File: tb/tb_fright_mode_ctrl.sv
// tb/tb_fright_mode_ctrl.sv - self-checking bench for fright_mode_ctrl against a rule-level model
module tb_fright_mode_ctrl;

  localparam int FF = 10;
  localparam int FL = 3;
  localparam int RF = 5;
  localparam int HR = 12;

  logic       clk = 1'b0;
  logic       reset, frame_tick, big_pellet_eaten, win;
  logic [9:0] pacX, pacY, ghostX, ghostY;
  logic [7:0] ghost_survival_timer;
  logic       slow_ghost_intercept, ghost_flash, pacman_caught;
  logic [1:0] ghost_state;

  int vectors = 0;
  int miscompares = 0;

  // model: 0 normal, 1 fright, 2 eaten
  int m_state = 0, m_timer = 0, m_lock = 0, m_int = 0, m_caught = 0;

  fright_mode_ctrl #(.FRIGHT_FRAMES(FF), .FLASH_FRAMES(FL), .RESPAWN_FRAMES(RF), .HIT_RADIUS(HR)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .big_pellet_eaten(big_pellet_eaten), .win(win),
    .pacX(pacX), .pacY(pacY), .ghostX(ghostX), .ghostY(ghostY),
    .ghost_survival_timer(ghost_survival_timer), .slow_ghost_intercept(slow_ghost_intercept),
    .ghost_state(ghost_state), .ghost_flash(ghost_flash), .pacman_caught(pacman_caught)
  );

  always #5 clk = ~clk;

  function automatic bit near();
    int ax, ay;
    ax = int'(pacX) - int'(ghostX);
    ay = int'(pacY) - int'(ghostY);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    return (ax < HR) && (ay < HR);
  endfunction

  function automatic logic [12:0] exp_vec();
    logic f;
    f = (m_state == 1) && (m_timer > 0) && (m_timer <= FL);
    return {2'(m_state), 8'(m_timer), 1'(m_int), 1'(m_caught), f};
  endfunction

  function automatic logic [12:0] act_vec();
    return {ghost_state, ghost_survival_timer, slow_ghost_intercept, pacman_caught, ghost_flash};
  endfunction

  // Advance the model by the rules for the current inputs, then clock the DUT.
  task automatic step();
    bit h;
    h = near();
    m_int = 0;
    m_caught = 0;
    if (reset) begin
      m_state = 0; m_timer = 0; m_lock = 0;
    end else if (!win) begin
      if (m_state == 0) begin
        if (big_pellet_eaten) begin
          m_state = 1; m_timer = FF;
          if (!h) m_lock = 0;
        end else if (h && m_lock == 0) begin
          m_caught = 1; m_lock = 1;
        end else if (!h) m_lock = 0;
      end else if (m_state == 1) begin
        if (h) begin
          m_state = 2; m_timer = RF; m_int = 1;
        end else if (big_pellet_eaten) m_timer = FF;
        else if (frame_tick) begin
          m_timer = m_timer - 1;
          if (m_timer == 0) begin m_state = 0; m_lock = 0; end
        end
      end else if (frame_tick) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin m_state = 0; m_lock = int'(h); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  task automatic place(input int px, input int py, input int gx, input int gy);
    pacX = 10'(px); pacY = 10'(py); ghostX = 10'(gx); ghostY = 10'(gy);
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; big_pellet_eaten = 1'b0; win = 1'b0;
    place(500, 500, 200, 200);
    step();
    vectors++;
    if (act_vec() !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_values got %h expected 0000", act_vec());
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      frame_tick = 1'b1;
      step();
      vectors++;
      if (act_vec() !== exp_vec() || ghost_state !== 2'b00 || ghost_survival_timer !== 8'd0) begin
        miscompares++;
        $display("FAIL normal_ticks[%0d] got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    frame_tick = 1'b0;
    big_pellet_eaten = 1'b1; step(); big_pellet_eaten = 1'b0;
    vectors++;
    if (ghost_state !== 2'b01 || ghost_survival_timer !== 8'd10 || act_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL enter_fright got state=%b timer=%0d expected state=01 timer=10", ghost_state, ghost_survival_timer);
    end
  endtask

  task automatic test_fright_countdown();
    tick_n(6);
    vectors++;
    if (ghost_survival_timer !== 8'd4 || ghost_flash !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_flash got timer=%0d flash=%b expected timer=4 flash=0", ghost_survival_timer, ghost_flash);
    end
    tick_n(1);
    vectors++;
    if (ghost_survival_timer !== 8'd3 || ghost_flash !== 1'b1 || ghost_state !== 2'b01) begin
      miscompares++;
      $display("FAIL flash_window got timer=%0d flash=%b expected timer=3 flash=1", ghost_survival_timer, ghost_flash);
    end
    tick_n(3);
    vectors++;
    if (ghost_survival_timer !== 8'd0 || ghost_state !== 2'b00 || ghost_flash !== 1'b0) begin
      miscompares++;
      $display("FAIL fright_expire got state=%b timer=%0d flash=%b expected 00/0/0", ghost_state, ghost_survival_timer, ghost_flash);
    end
    big_pellet_eaten = 1'b1; step(); big_pellet_eaten = 1'b0;
    tick_n(5);
    big_pellet_eaten = 1'b1; frame_tick = 1'b1; step(); big_pellet_eaten = 1'b0; frame_tick = 1'b0;
    vectors++;
    if (ghost_survival_timer !== 8'd10 || ghost_state !== 2'b01) begin
      miscompares++;
      $display("FAIL reload_with_tick got timer=%0d expected 10", ghost_survival_timer);
    end
  endtask

  task automatic test_intercept();
    place(1020, 200, 5, 200);
    step();
    vectors++;
    if (ghost_state !== 2'b01 || slow_ghost_intercept !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_no_wrap got state=%b intercept=%b expected 01/0", ghost_state, slow_ghost_intercept);
    end
    place(212, 200, 200, 200);
    step();
    vectors++;
    if (ghost_state !== 2'b01 || slow_ghost_intercept !== 1'b0 || ghost_survival_timer !== 8'd10) begin
      miscompares++;
      $display("FAIL radius_boundary got state=%b intercept=%b expected 01/0", ghost_state, slow_ghost_intercept);
    end
    place(211, 200, 200, 200);
    step();
    vectors++;
    if (slow_ghost_intercept !== 1'b1 || ghost_state !== 2'b10 || ghost_survival_timer !== 8'd5 || pacman_caught !== 1'b0) begin
      miscompares++;
      $display("FAIL intercept got int=%b state=%b timer=%0d expected 1/10/5", slow_ghost_intercept, ghost_state, ghost_survival_timer);
    end
    step();
    vectors++;
    if (slow_ghost_intercept !== 1'b0 || ghost_state !== 2'b10) begin
      miscompares++;
      $display("FAIL intercept_one_cycle got int=%b state=%b expected 0/10", slow_ghost_intercept, ghost_state);
    end
  endtask

  task automatic test_eaten_respawn();
    int pulses;
    big_pellet_eaten = 1'b1; step(); big_pellet_eaten = 1'b0;
    vectors++;
    if (act_vec() !== exp_vec() || ghost_survival_timer !== 8'd5) begin
      miscompares++;
      $display("FAIL eaten_ignores_pellet got %h expected %h", act_vec(), exp_vec());
    end
    pulses = 0;
    frame_tick = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); pulses += int'(pacman_caught); end
    frame_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); pulses += int'(pacman_caught); end
    vectors++;
    if (ghost_state !== 2'b00 || pulses != 0) begin
      miscompares++;
      $display("FAIL respawn_on_pacman got state=%b pulses=%0d expected 00/0", ghost_state, pulses);
    end
    place(300, 200, 200, 200); step();
    place(211, 200, 200, 200); step();
    vectors++;
    if (pacman_caught !== 1'b1 || slow_ghost_intercept !== 1'b0) begin
      miscompares++;
      $display("FAIL caught_pulse got caught=%b expected 1", pacman_caught);
    end
    pulses = 0;
    for (int i = 0; i < 100; i++) begin step(); pulses += int'(pacman_caught); end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL caught_lock got %0d extra pulses expected 0", pulses);
    end
  endtask

  task automatic test_simultaneous();
    place(300, 200, 200, 200); step();
    place(211, 200, 200, 200);
    big_pellet_eaten = 1'b1;
    step();
    vectors++;
    if (ghost_state !== 2'b01 || pacman_caught !== 1'b0 || ghost_survival_timer !== 8'd10) begin
      miscompares++;
      $display("FAIL pellet_beats_hit got state=%b caught=%b expected 01/0", ghost_state, pacman_caught);
    end
    step();
    big_pellet_eaten = 1'b0;
    vectors++;
    if (ghost_state !== 2'b10 || slow_ghost_intercept !== 1'b1 || pacman_caught !== 1'b0 || ghost_survival_timer !== 8'd5) begin
      miscompares++;
      $display("FAIL hit_beats_pellet got state=%b int=%b expected 10/1", ghost_state, slow_ghost_intercept);
    end
  endtask

  task automatic test_freeze();
    int pulses;
    place(300, 200, 200, 200);
    tick_n(5);
    big_pellet_eaten = 1'b1; step(); big_pellet_eaten = 1'b0;
    tick_n(4);
    win = 1'b1;
    place(211, 200, 200, 200);
    pulses = 0;
    frame_tick = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); pulses += int'(pacman_caught) + int'(slow_ghost_intercept); end
    frame_tick = 1'b0;
    vectors++;
    if (ghost_survival_timer !== 8'd6 || ghost_state !== 2'b01 || pulses != 0) begin
      miscompares++;
      $display("FAIL win_freeze got timer=%0d state=%b pulses=%0d expected 6/01/0", ghost_survival_timer, ghost_state, pulses);
    end
    win = 1'b0;
    place(300, 200, 200, 200);
    tick_n(1);
    vectors++;
    if (ghost_survival_timer !== 8'd5 || ghost_state !== 2'b01) begin
      miscompares++;
      $display("FAIL win_release got timer=%0d expected 5", ghost_survival_timer);
    end
  endtask

  task automatic test_reset_mid_eaten();
    place(211, 200, 200, 200); step();
    vectors++;
    if (ghost_state !== 2'b10) begin
      miscompares++;
      $display("FAIL enter_eaten got state=%b expected 10", ghost_state);
    end
    reset = 1'b1; step(); reset = 1'b0;
    vectors++;
    if (act_vec() !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mid_eaten got %h expected 0000", act_vec());
    end
    place(300, 200, 200, 200); step();
  endtask

  task automatic test_random();
    int gx, gy, px, py;
    int g_sel[3] = '{5, 200, 1018};
    gx = 200; gy = 200; px = 300; py = 200;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        gx = g_sel[$urandom_range(0, 2)];
        gy = g_sel[$urandom_range(0, 2)];
      end
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
        end else begin
          px = gx + $urandom_range(0, 30) - 15;
          py = gy + $urandom_range(0, 30) - 15;
          if (px < 0) px = 0;
          if (px > 1023) px = 1023;
          if (py < 0) py = 0;
          if (py > 1023) py = 1023;
        end
      end
      place(px, py, gx, gy);
      frame_tick       = ($urandom_range(0, 2) == 0);
      big_pellet_eaten = ($urandom_range(0, 39) == 0);
      win              = ($urandom_range(0, 29) == 0);
      reset            = ($urandom_range(0, 499) == 0);
      step();
      vectors++;
      if (act_vec() !== exp_vec() || (slow_ghost_intercept && pacman_caught)) begin
        miscompares++;
        $display("FAIL random[%0d] got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    reset = 1'b0; win = 1'b0; frame_tick = 1'b0; big_pellet_eaten = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fright_countdown();
    test_intercept();
    test_eaten_respawn();
    test_simultaneous();
    test_freeze();
    test_reset_mid_eaten();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
